// File: rtl/seq_multiplier_if.sv
// Handshake/bus bundle between a controller and the shared shift-add multiplier.
// The controller (master) drives start/a/b; the multiplier (slave) returns busy/done/m.
// Pure wiring, no storage; WIDTH must match the attached multiplier instance.
interface seq_multiplier_if #(
   parameter int WIDTH = 4
);
   logic               start;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic               busy;
   logic               done;
   logic [2*WIDTH-1:0] m;

   modport master (output start, output a, output b, input busy, input done, input m);
   modport slave  (input start, input a, input b, output busy, output done, output m);
endinterface

// File: rtl/seq_multiplier.sv
// Purpose: WIDTH x WIDTH shift-add multiplier reusing a single adder; MULT_SIGNED_EN selects two's complement operands.
// Latency: start accepted at edge E0 -> done pulse with m valid after edge E0+WIDTH+1; one product per WIDTH+1 cycles.
// Backpressure: none; start is ignored while busy, and accepted in IDLE or in the FINISH cycle (back-to-back).
module seq_multiplier #(
   parameter int WIDTH = 4
) (
   input logic             clk,
   input logic             rst,
   seq_multiplier_if.slave bus
);
   localparam int PW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

   state_t           state;
   logic [PW-1:0]    mcand;
   logic [PW-1:0]    acc;
   logic [PW-1:0]    m_q;
   logic [WIDTH-1:0] mplr;
   logic [CW-1:0]    cnt;
   logic             busy_q;
   logic             done_q;
   logic             accept;
   logic [WIDTH-1:0] a_load;
   logic [WIDTH-1:0] b_load;
   logic [PW-1:0]    result;

   // A new request is taken when idle or in the single FINISH cycle.
   assign accept = bus.start && ((state == IDLE) || (state == FINISH));

`ifdef MULT_SIGNED_EN
   logic sign_q;

   // Magnitudes fit in WIDTH unsigned bits, including the most-negative value.
   always_comb begin
      a_load = bus.a[WIDTH-1] ? (~bus.a + 1'b1) : bus.a;
      b_load = bus.b[WIDTH-1] ? (~bus.b + 1'b1) : bus.b;
      result = sign_q ? (~acc + 1'b1) : acc;
   end
`else
   // Unsigned operands pass straight through.
   always_comb begin
      a_load = bus.a;
      b_load = bus.b;
      result = acc;
   end
`endif

   // Control FSM and datapath: one shift-add step per RUN cycle, result written in FINISH.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         mcand  <= '0;
         acc    <= '0;
         m_q    <= '0;
         mplr   <= '0;
         cnt    <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
`ifdef MULT_SIGNED_EN
         sign_q <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               state <= IDLE;
            end
            RUN: begin
               if (mplr[0]) begin
                  acc <= acc + mcand;
               end
               mcand <= mcand << 1;
               mplr  <= mplr >> 1;
               cnt   <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) begin
                  state  <= FINISH;
                  busy_q <= 1'b0;
               end
            end
            FINISH: begin
               m_q    <= result;
               done_q <= 1'b1;
               state  <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
         // Loading after the case lets a FINISH-cycle start override the return to IDLE.
         if (accept) begin
            mcand  <= PW'(a_load);
            mplr   <= b_load;
            acc    <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
`ifdef MULT_SIGNED_EN
            sign_q <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
`endif
         end
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.m    = m_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: directed WIDTH=4 scenarios plus a WIDTH=8 random sweep.
// Expected products and due edges are queued at stimulus time and popped on each done pulse.
module tb_seq_multiplier;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst4;
   logic rst8;
   int   edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   seq_multiplier_if #(.WIDTH(4)) bus4 ();
   seq_multiplier_if #(.WIDTH(8)) bus8 ();

   seq_multiplier #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst4), .bus(bus4.slave));
   seq_multiplier #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst8), .bus(bus8.slave));

   typedef struct {
      logic [15:0] prod;
      int          due;
   } exp_t;

   exp_t q4[$];
   exp_t q8[$];
   exp_t e4;
   exp_t e8;
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b);
`ifdef MULT_SIGNED_EN
      logic signed [15:0] sa;
      logic signed [15:0] sb;
      sa = {{8{a[7]}}, a};
      sb = {{8{b[7]}}, b};
      return 16'(sa * sb);
`else
      return 16'(a) * 16'(b);
`endif
   endfunction

   // Scoreboard: every done pulse must match the oldest outstanding expectation, value and timing.
   always @(posedge clk) begin
      #1;
      if (bus4.done === 1'b1) begin
         if (q4.size() == 0) begin
            check("w4_spurious_done", 32'd1, 32'd0);
         end else begin
            e4 = q4.pop_front();
            check("w4_m", 32'(bus4.m), 32'(e4.prod));
            check("w4_latency", edge_cnt, e4.due);
         end
      end
      if (bus8.done === 1'b1) begin
         if (q8.size() == 0) begin
            check("w8_spurious_done", 32'd1, 32'd0);
         end else begin
            e8 = q8.pop_front();
            check("w8_m", 32'(bus8.m), 32'(e8.prod));
            check("w8_latency", edge_cnt, e8.due);
         end
      end
   end

   // One-cycle start pulse; returns at the negedge just after the accepting edge.
   task automatic start4(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp, input bit push);
      exp_t ent;
      @(negedge clk);
      bus4.start = 1'b1;
      bus4.a     = a;
      bus4.b     = b;
      if (push) begin
         ent.prod = 16'(exp);
         ent.due  = edge_cnt + 1 + 5;
         q4.push_back(ent);
      end
      @(negedge clk);
      bus4.start = 1'b0;
   endtask

   task automatic start8(input logic [7:0] a, input logic [7:0] b);
      exp_t ent;
      @(negedge clk);
      bus8.start = 1'b1;
      bus8.a     = a;
      bus8.b     = b;
      ent.prod   = ref8(a, b);
      ent.due    = edge_cnt + 1 + 9;
      q8.push_back(ent);
      @(negedge clk);
      bus8.start = 1'b0;
   endtask

   task automatic drain4(input string tag);
      for (int i = 0; i < 40 && q4.size() != 0; i++) @(negedge clk);
      if (q4.size() != 0) begin
         check({tag, "_timeout"}, q4.size(), 0);
         q4.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic drain8(input string tag);
      for (int i = 0; i < 40 && q8.size() != 0; i++) @(negedge clk);
      if (q8.size() != 0) begin
         check({tag, "_timeout"}, q8.size(), 0);
         q8.delete();
      end
   endtask

   initial begin
      exp_t ent;
      bus4.start = 1'b0; bus4.a = '0; bus4.b = '0;
      bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
      rst4 = 1'b1;
      rst8 = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(bus4.busy), 0);
      check("rst_done", 32'(bus4.done), 0);
      check("rst_m", 32'(bus4.m), 0);
      check("rst_m8", 32'(bus8.m), 0);
      rst4 = 1'b0;
      rst8 = 1'b0;
      @(negedge clk);

      // 3 x 5: busy for exactly four RUN cycles, low again in FINISH, result held afterwards.
      start4(4'd3, 4'd5, 8'd15, 1'b1);
      for (int i = 0; i < 4; i++) begin
         check("busy_run", 32'(bus4.busy), 1);
         @(negedge clk);
      end
      check("busy_finish", 32'(bus4.busy), 0);
      drain4("mul_3x5");
      check("m_hold_15", 32'(bus4.m), 32'd15);
      check("busy_idle", 32'(bus4.busy), 0);

`ifdef MULT_SIGNED_EN
      start4(4'd15, 4'd15, 8'd1, 1'b1);
`else
      start4(4'd15, 4'd15, 8'd225, 1'b1);
`endif
      drain4("mul_15x15");
      start4(4'd0, 4'd9, 8'd0, 1'b1);
      drain4("mul_0x9");

      // Start on the 2nd RUN cycle must be ignored.
      start4(4'd2, 4'd3, 8'd6, 1'b1);
      @(negedge clk);
      bus4.start = 1'b1; bus4.a = 4'd7; bus4.b = 4'd7;
      @(negedge clk);
      bus4.start = 1'b0;
      drain4("ignore_busy");
      repeat (6) @(negedge clk);
      check("ignore_m", 32'(bus4.m), 32'd6);

      // start held through FINISH: second request accepted on the FINISH edge.
      start4(4'd2, 4'd3, 8'd6, 1'b1);
      @(negedge clk);
      bus4.start = 1'b1; bus4.a = 4'd6; bus4.b = 4'd6;
      ent.prod = 16'd36;
      ent.due  = edge_cnt + 4 + 5;
      q4.push_back(ent);
      repeat (4) @(negedge clk);
      bus4.start = 1'b0;
      check("b2b_busy", 32'(bus4.busy), 1);
      drain4("back_to_back");

      // Reset on the 3rd RUN cycle aborts silently.
      start4(4'd5, 4'd5, 8'd0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst4 = 1'b1;
      bus4.start = 1'b1; bus4.a = 4'd3; bus4.b = 4'd3;
      @(negedge clk);
      rst4 = 1'b0;
      bus4.start = 1'b0;
      check("abort_busy", 32'(bus4.busy), 0);
      check("abort_done", 32'(bus4.done), 0);
      check("abort_m", 32'(bus4.m), 0);
      repeat (10) @(negedge clk);
      check("abort_idle_busy", 32'(bus4.busy), 0);
      start4(4'd2, 4'd2, 8'd4, 1'b1);
      drain4("after_abort");

      // Sign-sensitive vectors.
`ifdef MULT_SIGNED_EN
      start4(4'b1101, 4'b0101, 8'hF1, 1'b1);
`else
      start4(4'b1101, 4'b0101, 8'd65, 1'b1);
`endif
      drain4("mul_13x5");
      start4(4'b1000, 4'b1000, 8'd64, 1'b1);
      drain4("mul_8x8");

      // WIDTH=8 sweep with corners first.
      for (int i = 0; i < 200; i++) begin
         if (i == 0) start8(8'hFF, 8'hFF);
         else if (i == 1) start8(8'h80, 8'h80);
         else if (i == 2) start8(8'h00, 8'hA5);
         else start8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
         drain8("sweep8");
      end
      repeat (12) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
